prime_stream_checker: RTL and testbench

//  Consumer/verifier for the prime-search result stream: accepts (number, prime flag, running prime count).

---
 rtl/prime_chk_pkg.sv | 20 ++
 rtl/prime_rem_div.sv | 56 +++++
 rtl/prime_stream_checker.sv | 172 +++++++++++++++++
 tb/tb_prime_stream_checker.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prime_chk_pkg.sv
// Shared types and constants for the prime result-stream checker.
package prime_chk_pkg;

    localparam int DEF_WIDTH   = 10;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_MAX_NUM = 1000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        CMP
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_PRIME = 2'b01;
    localparam logic [1:0] ERR_COUNT = 2'b10;
    localparam logic [1:0] ERR_FAULT = 2'b11;

endpackage

// File: rtl/prime_rem_div.sv
// Restoring divider producing only the remainder; one quotient bit per cycle.
// done is raised during the last iteration cycle, with remainder already final.
module prime_rem_div #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] next_rem;

    // A set top bit of diff is the borrow: the trial subtraction failed, keep shifted.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        next_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            rem_q   <= '0;
            quo_q   <= dividend;
            count_q <= CW'(WIDTH);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            rem_q   <= next_rem;
            quo_q   <= quo_q << 1;
            count_q <= count_q - 1'b1;
            if (count_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done      = busy_q && (count_q == CW'(1));
    assign remainder = next_rem;

endmodule

// File: rtl/prime_stream_checker.sv
// Scoreboard for the prime-search result stream: recomputes primality by trial
// division and flags flag/count mismatches plus ordering and range faults.
module prime_stream_checker
    import prime_chk_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_NUM = DEF_MAX_NUM
) (
    input  logic             SysClk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InNumber,
    input  logic             InPrime,
    input  logic [CNT_W-1:0] InCount,
    output logic             ErrValid,
    output logic [1:0]       ErrCode,
    output logic [WIDTH-1:0] ErrNumber,
    output logic [CNT_W-1:0] ErrTotal,
    output logic [CNT_W-1:0] ExpCount,
    output logic [CNT_W-1:0] Checked
);

    localparam logic [WIDTH:0] MAX_N = (WIDTH + 1)'(MAX_NUM);

    state_t           state;
    logic [WIDTH-1:0] num_q;
    logic             prime_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] d_q;
    logic             exp_q;
    logic             fault_q;
    logic             range_q;
    logic [WIDTH-1:0] last_num_q;
    logic             last_valid_q;
    logic             div_start_q;

    logic             div_done;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] d_inc;
    logic [2*WIDTH-1:0] d_wide;
    logic [2*WIDTH-1:0] d_sq;
    logic             range_bad;
    logic             order_bad;
    logic [CNT_W-1:0] exp_count_new;
    logic [1:0]       cmp_code;

    prime_rem_div #(.WIDTH(WIDTH)) u_div (
        .clk       (SysClk),
        .rst_n     (Reset_n),
        .start     (div_start_q),
        .dividend  (num_q),
        .divisor   (d_q),
        .done      (div_done),
        .remainder (div_rem)
    );

    // Once (d+1)^2 exceeds N no untried divisor can exist, so N is prime.
    always_comb begin
        d_inc         = d_q + 1'b1;
        d_wide        = {{WIDTH{1'b0}}, d_inc};
        d_sq          = d_wide * d_wide;
        range_bad     = {1'b0, num_q} > MAX_N;
        order_bad     = last_valid_q && (num_q <= last_num_q);
        exp_count_new = ExpCount + {{(CNT_W-1){1'b0}}, exp_q & ~fault_q};
        cmp_code      = ERR_NONE;
        if (fault_q) begin
            cmp_code = ERR_FAULT;
        end else if (prime_q != exp_q) begin
            cmp_code = ERR_PRIME;
        end else if (count_q != exp_count_new) begin
            cmp_code = ERR_COUNT;
        end
    end

    assign InReady = (state == IDLE) && !Clear;

    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            num_q        <= '0;
            prime_q      <= 1'b0;
            count_q      <= '0;
            d_q          <= '0;
            exp_q        <= 1'b0;
            fault_q      <= 1'b0;
            range_q      <= 1'b0;
            last_num_q   <= '0;
            last_valid_q <= 1'b0;
            div_start_q  <= 1'b0;
            ErrValid     <= 1'b0;
            ErrCode      <= ERR_NONE;
            ErrNumber    <= '0;
            ErrTotal     <= '0;
            ExpCount     <= '0;
            Checked      <= '0;
        end else begin
            ErrValid    <= 1'b0;
            div_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Clear) begin
                        ExpCount     <= '0;
                        ErrTotal     <= '0;
                        Checked      <= '0;
                        last_valid_q <= 1'b0;
                    end else if (InValid) begin
                        num_q   <= InNumber;
                        prime_q <= InPrime;
                        count_q <= InCount;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    fault_q <= range_bad || order_bad;
                    range_q <= range_bad;
                    if (range_bad || order_bad) begin
                        exp_q <= 1'b0;
                        state <= CMP;
                    end else if (num_q < WIDTH'(2)) begin
                        exp_q <= 1'b0;
                        state <= CMP;
                    end else if (num_q < WIDTH'(4)) begin
                        exp_q <= 1'b1;
                        state <= CMP;
                    end else begin
                        d_q         <= WIDTH'(2);
                        div_start_q <= 1'b1;
                        state       <= DIV;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        d_q <= d_inc;
                        if (div_rem == '0) begin
                            exp_q <= 1'b0;
                            state <= CMP;
                        end else if (d_sq > {{WIDTH{1'b0}}, num_q}) begin
                            exp_q <= 1'b1;
                            state <= CMP;
                        end else begin
                            div_start_q <= 1'b1;
                        end
                    end
                end
                CMP: begin
                    ExpCount <= exp_count_new;
                    if (cmp_code != ERR_NONE) begin
                        ErrValid  <= 1'b1;
                        ErrCode   <= cmp_code;
                        ErrNumber <= num_q;
                        if (ErrTotal != '1) begin
                            ErrTotal <= ErrTotal + 1'b1;
                        end
                    end
                    if (Checked != '1) begin
                        Checked <= Checked + 1'b1;
                    end
                    if (!range_q) begin
                        last_num_q   <= num_q;
                        last_valid_q <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_stream_checker.sv
// Self-checking bench for prime_stream_checker: a reference model pushes the
// expected outcome of each beat into a queue, popped when the checker returns to idle.
module tb_prime_stream_checker;

    localparam int WIDTH   = 10;
    localparam int CNT_W   = 8;
    localparam int MAX_NUM = 1000;
    localparam int BUDGET  = 2000;

    logic             SysClk = 1'b0;
    logic             Reset_n = 1'b0;
    logic             Clear = 1'b0;
    logic             InValid = 1'b0;
    logic             InReady;
    logic [WIDTH-1:0] InNumber = '0;
    logic             InPrime = 1'b0;
    logic [CNT_W-1:0] InCount = '0;
    logic             ErrValid;
    logic [1:0]       ErrCode;
    logic [WIDTH-1:0] ErrNumber;
    logic [CNT_W-1:0] ErrTotal;
    logic [CNT_W-1:0] ExpCount;
    logic [CNT_W-1:0] Checked;

    typedef struct {
        int number;
        int err_valid;
        int code;
        int err_number;
        int exp_count;
        int err_total;
        int checked;
        int latency;
    } expect_t;

    expect_t sb_q[$];
    int compared = 0;
    int mismatched = 0;

    int m_exp_count, m_err_total, m_checked, m_last_num, m_last_valid;
    int m_err_code, m_err_number;
    int prod_count;

    prime_stream_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_NUM(MAX_NUM)) dut (
        .SysClk    (SysClk),
        .Reset_n   (Reset_n),
        .Clear     (Clear),
        .InValid   (InValid),
        .InReady   (InReady),
        .InNumber  (InNumber),
        .InPrime   (InPrime),
        .InCount   (InCount),
        .ErrValid  (ErrValid),
        .ErrCode   (ErrCode),
        .ErrNumber (ErrNumber),
        .ErrTotal  (ErrTotal),
        .ExpCount  (ExpCount),
        .Checked   (Checked)
    );

    always #5 SysClk = ~SysClk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int isPrime(input int n);
        if (n < 2) return 0;
        for (int i = 2; i * i <= n; i++) begin
            if (n % i == 0) return 0;
        end
        return 1;
    endfunction

    // Number of divisors the checker tries before deciding, for N >= 4.
    function automatic int trials(input int n);
        int d = 2;
        int k = 0;
        while (1) begin
            k++;
            if (n % d == 0) return k;
            if ((d + 1) * (d + 1) > n) return k;
            d++;
        end
        return k;
    endfunction

    function automatic int satInc(input int v);
        return (v == 255) ? 255 : v + 1;
    endfunction

    task automatic modelReset();
        m_exp_count  = 0;
        m_err_total  = 0;
        m_checked    = 0;
        m_last_num   = 0;
        m_last_valid = 0;
        m_err_code   = 0;
        m_err_number = 0;
        sb_q.delete();
    endtask

    task automatic driveBeat(input int n, input int p, input int c);
        int guard = 0;
        @(negedge SysClk);
        while (!InReady && guard < BUDGET) begin
            @(negedge SysClk);
            guard++;
        end
        if (!InReady) checkOutput("ready_timeout", 0, 1);
        InValid  = 1'b1;
        InNumber = WIDTH'(n);
        InPrime  = p[0];
        InCount  = CNT_W'(c);
        @(posedge SysClk);
        #1;
        InValid = 1'b0;
    endtask

    task automatic waitDone();
        int lat = 0;
        expect_t e;
        do begin
            @(negedge SysClk);
            lat++;
        end while (!InReady && lat < BUDGET);
        if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        checkOutput($sformatf("latency_%0d", e.number), lat, e.latency);
        checkOutput($sformatf("err_valid_%0d", e.number), int'(ErrValid), e.err_valid);
        checkOutput($sformatf("err_code_%0d", e.number), int'(ErrCode), e.code);
        checkOutput($sformatf("err_number_%0d", e.number), int'(ErrNumber), e.err_number);
        checkOutput($sformatf("exp_count_%0d", e.number), int'(ExpCount), e.exp_count);
        checkOutput($sformatf("err_total_%0d", e.number), int'(ErrTotal), e.err_total);
        checkOutput($sformatf("checked_%0d", e.number), int'(Checked), e.checked);
    endtask

    task automatic applyStimulus(input int n, input int p, input int c);
        expect_t e;
        int range_f, order_f, fault, ex, code;
        driveBeat(n, p, c);
        range_f = (n > MAX_NUM);
        order_f = m_last_valid && (n <= m_last_num);
        fault   = range_f || order_f;
        ex      = fault ? 0 : isPrime(n);
        if (!fault && ex) m_exp_count = (m_exp_count + 1) % 256;
        if (fault) code = 3;
        else if (p != ex) code = 1;
        else if (c != m_exp_count) code = 2;
        else code = 0;
        if (code != 0) begin
            m_err_total  = satInc(m_err_total);
            m_err_code   = code;
            m_err_number = n;
        end
        m_checked = satInc(m_checked);
        if (!range_f) begin
            m_last_num   = n;
            m_last_valid = 1;
        end
        e.number     = n;
        e.err_valid  = (code != 0);
        e.code       = m_err_code;
        e.err_number = m_err_number;
        e.exp_count  = m_exp_count;
        e.err_total  = m_err_total;
        e.checked    = m_checked;
        e.latency    = (fault || n < 4) ? 3 : trials(n) * (WIDTH + 1) + 3;
        sb_q.push_back(e);
        waitDone();
    endtask

    task automatic sendGood(input int n);
        prod_count = (prod_count + isPrime(n)) % 256;
        applyStimulus(n, isPrime(n), prod_count);
    endtask

    task automatic resetDut();
        Reset_n = 1'b0;
        repeat (2) @(negedge SysClk);
        Reset_n = 1'b1;
        modelReset();
        prod_count = 0;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_in_ready"}, int'(InReady), 1);
        checkOutput({tag, "_err_valid"}, int'(ErrValid), 0);
        checkOutput({tag, "_err_code"}, int'(ErrCode), 0);
        checkOutput({tag, "_err_number"}, int'(ErrNumber), 0);
        checkOutput({tag, "_err_total"}, int'(ErrTotal), 0);
        checkOutput({tag, "_exp_count"}, int'(ExpCount), 0);
        checkOutput({tag, "_checked"}, int'(Checked), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        prod_count = 0;
        repeat (3) @(negedge SysClk);
        checkIdleZero("reset");
        Reset_n = 1'b1;

        $display("[TB] correct stream 1..10");
        for (int n = 1; n <= 10; n++) sendGood(n);
        checkOutput("stream10_err_total", int'(ErrTotal), 0);
        checkOutput("stream10_exp_count", int'(ExpCount), 4);
        checkOutput("stream10_checked", int'(Checked), 10);

        $display("[TB] count mismatch, order and range faults");
        applyStimulus(11, 1, 7);
        checkOutput("n11_code", int'(ErrCode), 2);
        checkOutput("n11_exp_count", int'(ExpCount), 5);
        applyStimulus(9, 0, 5);
        checkOutput("n9_code", int'(ErrCode), 3);
        applyStimulus(1001, 0, 5);
        checkOutput("n1001_code", int'(ErrCode), 3);
        applyStimulus(10, 0, 5);
        checkOutput("n10_no_error_total", int'(ErrTotal), 3);

        $display("[TB] prime flag mismatch at 719");
        resetDut();
        for (int n = 1; n <= 100; n++) sendGood(n);
        for (int n = 700; n <= 717; n++) sendGood(n);
        applyStimulus(719, 0, prod_count + 1);
        checkOutput("n719_code", int'(ErrCode), 1);
        checkOutput("n719_number", int'(ErrNumber), 719);

        $display("[TB] reset during division");
        resetDut();
        driveBeat(997, 1, 1);
        repeat (30) @(negedge SysClk);
        #2 Reset_n = 1'b0;
        #1 checkIdleZero("midreset");
        @(negedge SysClk);
        Reset_n = 1'b1;
        modelReset();
        applyStimulus(997, 1, 1);
        checkOutput("n997_exp_count", int'(ExpCount), 1);
        checkOutput("n997_err_total", int'(ErrTotal), 0);

        $display("[TB] error counter saturation and clear");
        repeat (300) applyStimulus(1001, 0, 0);
        checkOutput("sat_err_total", int'(ErrTotal), 255);
        checkOutput("sat_checked", int'(Checked), 255);
        @(negedge SysClk);
        Clear = 1'b1;
        @(negedge SysClk);
        Clear = 1'b0;
        m_exp_count  = 0;
        m_err_total  = 0;
        m_checked    = 0;
        m_last_valid = 0;
        checkOutput("clear_err_total", int'(ErrTotal), 0);
        checkOutput("clear_exp_count", int'(ExpCount), 0);
        checkOutput("clear_checked", int'(Checked), 0);
        applyStimulus(5, 1, 1);
        checkOutput("post_clear_err_total", int'(ErrTotal), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
